// File: rtl/button_pkg.sv
// Shared push-button definitions: FSM encoding, default timing and counter sizing.
package button_pkg;

  typedef enum logic [2:0] {
    StReleased    = 3'd0,
    StPressWait   = 3'd1,
    StPressed     = 3'd2,
    StLongHeld    = 3'd3,
    StReleaseWait = 3'd4
  } btn_state_e;

  // 5 ms and 1 s at 50 MHz
  localparam int unsigned DefaultStableCycles = 250000;
  localparam int unsigned DefaultLongCycles   = 50000000;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, synchronous reset to 0.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_meta;
  logic [Width-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button pin into a clean level plus press/release/long-press pulses.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DefaultStableCycles,
  parameter int unsigned LONG_CYCLES   = DefaultLongCycles
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_b,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long_press,
  output logic o_held
);

  localparam int unsigned CntW = cnt_width(STABLE_CYCLES, LONG_CYCLES);

  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] LongLast   = CntW'(LONG_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  logic w_s;

  btn_state_e      r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_held_flag, w_held_flag_d;

  logic r_level, r_press, r_release, r_long, r_held;

  sync_2ff #(
    .Width (1)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_b),
    .o_q     (w_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StReleased;
      r_cnt       <= '0;
      r_held_flag <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_held_flag <= w_held_flag_d;
    end
  end

  // The cycle that sees the first differing sample counts as sample 1 of the new level.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_held_flag_d = r_held_flag;
    unique case (r_state)
      StReleased: begin
        if (w_s) begin
          if (STABLE_CYCLES == 1) begin
            w_state_d = StPressed;
            w_cnt_d   = '0;
          end else begin
            w_state_d = StPressWait;
            w_cnt_d   = CntOne;
          end
        end
      end
      StPressWait: begin
        if (!w_s) begin
          w_state_d = StReleased;
          w_cnt_d   = '0;
        end else if (r_cnt == StableLast) begin
          w_state_d = StPressed;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CntOne;
        end
      end
      StPressed: begin
        if (!w_s) begin
          w_held_flag_d = 1'b0;
          if (STABLE_CYCLES == 1) begin
            w_state_d = StReleased;
            w_cnt_d   = '0;
          end else begin
            w_state_d = StReleaseWait;
            w_cnt_d   = CntOne;
          end
        end else if (r_cnt == LongLast) begin
          w_state_d = StLongHeld;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CntOne;
        end
      end
      StLongHeld: begin
        if (!w_s) begin
          w_held_flag_d = 1'b1;
          if (STABLE_CYCLES == 1) begin
            w_state_d = StReleased;
            w_cnt_d   = '0;
          end else begin
            w_state_d = StReleaseWait;
            w_cnt_d   = CntOne;
          end
        end
      end
      StReleaseWait: begin
        if (w_s) begin
          w_state_d = r_held_flag ? StLongHeld : StPressed;
          w_cnt_d   = '0;
        end else if (r_cnt == StableLast) begin
          w_state_d     = StReleased;
          w_cnt_d       = '0;
          w_held_flag_d = 1'b0;
        end else begin
          w_cnt_d = r_cnt + CntOne;
        end
      end
      default: begin
        w_state_d = StReleased;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Outputs trail the state by one cycle; pulses are edges of the level/held registers,
  // so bouncing back out of RELEASE_WAIT never re-fires press or long_press.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_level   <= (r_state == StPressed) || (r_state == StLongHeld) ||
                   (r_state == StReleaseWait);
      r_held    <= (r_state == StLongHeld) || ((r_state == StReleaseWait) && r_held_flag);
      r_press   <= (r_state == StPressed) && !r_level;
      r_release <= (r_state == StReleased) && r_level;
      r_long    <= (r_state == StLongHeld) && !r_held;
    end
  end

  assign o_level      = r_level;
  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_long_press = r_long;
  assign o_held       = r_held;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4, LONG_CYCLES=20.
module tb_button_debouncer;

  logic clk;
  logic reset;
  logic b;
  logic level, press, release_o, long_press, held;

  int n_vec;
  int n_err;

  // per-scenario event log, edge index relative to the last clear_log
  int idx;
  int press_cnt, release_cnt, long_cnt;
  int press_edge, release_edge, long_edge, level_edge;

  button_debouncer #(
    .STABLE_CYCLES (4),
    .LONG_CYCLES   (20)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_b          (b),
    .o_level      (level),
    .o_press      (press),
    .o_release    (release_o),
    .o_long_press (long_press),
    .o_held       (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    idx          = 0;
    press_cnt    = 0;
    release_cnt  = 0;
    long_cnt     = 0;
    press_edge   = -1;
    release_edge = -1;
    long_edge    = -1;
    level_edge   = -1;
  endtask

  // One rising edge, then sample the outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (press) begin
      press_cnt++;
      press_edge = idx;
    end
    if (release_o) begin
      release_cnt++;
      release_edge = idx;
    end
    if (long_press) begin
      long_cnt++;
      long_edge = idx;
    end
    if (level && level_edge < 0) level_edge = idx;
    idx++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [4:0] bounce_pat;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    b     = 1'b0;
    clear_log();

    // Reset state
    ticks(2);
    check_eq("rst_level", int'(level), 0);
    check_eq("rst_press", int'(press), 0);
    check_eq("rst_release", int'(release_o), 0);
    check_eq("rst_long", int'(long_press), 0);
    check_eq("rst_held", int'(held), 0);
    reset = 1'b0;
    ticks(3);

    // Clean press, 12 cycles high, then release
    clear_log();
    b = 1'b1;
    ticks(12);
    check_eq("clean_press_cnt", press_cnt, 1);
    check_eq("clean_press_edge", press_edge, 6);
    check_eq("clean_level_edge", level_edge, 6);
    check_eq("clean_long_cnt", long_cnt, 0);
    check_eq("clean_level_hi", int'(level), 1);
    clear_log();
    b = 1'b0;
    ticks(10);
    check_eq("clean_rel_cnt", release_cnt, 1);
    check_eq("clean_rel_edge", release_edge, 6);
    check_eq("clean_level_lo", int'(level), 0);

    // Glitch: two cycles high
    clear_log();
    b = 1'b1;
    ticks(2);
    b = 1'b0;
    ticks(10);
    check_eq("glitch_press_cnt", press_cnt, 0);
    check_eq("glitch_rel_cnt", release_cnt, 0);
    check_eq("glitch_level_edge", level_edge, -1);

    // Bounce 1,1,1,0,1 then steady high; final rise is edge 4
    clear_log();
    bounce_pat = 5'b10111;
    for (int i = 0; i < 5; i++) begin
      b = bounce_pat[i];
      tick();
    end
    ticks(12);
    check_eq("bounce_press_cnt", press_cnt, 1);
    check_eq("bounce_press_edge", press_edge, 10);
    check_eq("bounce_level_edge", level_edge, 10);
    b = 1'b0;
    ticks(10);

    // Long hold: 40 cycles high, then low
    clear_log();
    b = 1'b1;
    ticks(40);
    check_eq("long_press_edge", press_edge, 6);
    check_eq("long_edge", long_edge, 26);
    check_eq("long_cnt", long_cnt, 1);
    check_eq("long_held_hi", int'(held), 1);
    clear_log();
    b = 1'b0;
    ticks(10);
    check_eq("long_rel_edge", release_edge, 6);
    check_eq("long_rel_cnt", release_cnt, 1);
    check_eq("long_held_lo", int'(held), 0);

    // Release bounce while LONG_HELD
    clear_log();
    b = 1'b1;
    ticks(30);
    b = 1'b0;
    ticks(2);
    b = 1'b1;
    ticks(15);
    check_eq("rb_rel_cnt", release_cnt, 0);
    check_eq("rb_long_cnt", long_cnt, 1);
    check_eq("rb_held", int'(held), 1);
    check_eq("rb_level", int'(level), 1);
    b = 1'b0;
    ticks(10);
    check_eq("rb_final_rel_cnt", release_cnt, 1);

    // Reset mid-press with B held high
    clear_log();
    b = 1'b1;
    ticks(10);
    check_eq("mid_level_pre", int'(level), 1);
    clear_log();
    reset = 1'b1;
    tick();
    check_eq("mid_rst_level", int'(level), 0);
    check_eq("mid_rst_press", int'(press), 0);
    check_eq("mid_rst_release", int'(release_o), 0);
    reset = 1'b0;
    ticks(12);
    check_eq("mid_press_edge", press_edge, 7);
    check_eq("mid_press_cnt", press_cnt, 1);
    check_eq("mid_rel_cnt", release_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
